// File: rtl/ln_if.sv
// Operand/result handshake bundle for the ln block.
// The master issues operands and accepts results; the slave is the ln datapath.
interface ln_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/ln.sv
// Natural log of an unsigned UQ3.6 operand to signed Q1.6, one operation in flight.
// Define LN_FAST_NORM_EN for single-cycle normalization (priority encoder) instead of bit-serial.
module ln #(
  parameter int LN2_Q16 = 45426,
  parameter int C2_COEF = 79
) (
  input  logic clk,
  input  logic rst,
  ln_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, NORM, SQ, SCALE, OUT} state_t;

  state_t             state;
  logic [8:0]         m;
  logic signed [3:0]  k;
  logic [15:0]        s2;
  logic [7:0]         out_data_q;
  logic               out_zero_q;
  logic               out_valid_q;

  logic [7:0]         f;
  logic [15:0]        mul_a;
  logic [7:0]         mul_b;
  logic [23:0]        prod;
  logic [16:0]        lm;
  logic signed [19:0] k_term;
  logic signed [19:0] r;
  logic signed [19:0] y;
  logic [7:0]         sat;

  assign f = m[7:0];

  // One shared 16x8 multiplier: F*F while squaring, S2*C2 while scaling.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_a = {8'd0, f};
    mul_b = f;
    if (state == SCALE) begin
      mul_a = s2;
      mul_b = 8'(C2_COEF);
    end
  end

  assign prod = {8'd0, mul_a} * {16'd0, mul_b};

  // ln(1+F/256) in Q0.16 via the quadratic approximation.
  assign lm = {1'b0, f, 8'd0} - {1'b0, prod[23:8]};

  // K only spans -6..+2, so K*ln2 is a mux of elaboration-time constants.
  always_comb begin
    k_term = '0;
    case (k)
      -4'sd6: k_term = 20'(-6 * LN2_Q16);
      -4'sd5: k_term = 20'(-5 * LN2_Q16);
      -4'sd4: k_term = 20'(-4 * LN2_Q16);
      -4'sd3: k_term = 20'(-3 * LN2_Q16);
      -4'sd2: k_term = 20'(-2 * LN2_Q16);
      -4'sd1: k_term = 20'(-1 * LN2_Q16);
      4'sd1:  k_term = 20'(LN2_Q16);
      4'sd2:  k_term = 20'(2 * LN2_Q16);
      default: k_term = '0;
    endcase
  end

  assign r = k_term + $signed({3'b000, lm});
  assign y = (r + 20'sd512) >>> 10;

  always_comb begin
    sat = y[7:0];
    if (y > 20'sd127)       sat = 8'h7f;
    else if (y < -20'sd128) sat = 8'h80;
  end

`ifdef LN_FAST_NORM_EN
  logic [3:0] lead_shift;

  // Highest set bit wins because the scan runs upward.
  always_comb begin
    lead_shift = 4'd8;
    for (int i = 0; i <= 8; i++) begin
      if (m[i]) lead_shift = 4'(8 - i);
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m           <= '0;
      k           <= '0;
      s2          <= '0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m <= bus.in_data;
            k <= 4'sd2;
            if (bus.in_data == 9'd0) begin
              out_data_q <= 8'h80;
              out_zero_q <= 1'b1;
              state      <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
`ifdef LN_FAST_NORM_EN
          m     <= m << lead_shift;
          k     <= 4'(k - $signed({1'b0, lead_shift}));
          state <= SQ;
`else
          if (m[8]) begin
            state <= SQ;
          end else begin
            m <= m << 1;
            k <= k - 4'sd1;
          end
`endif
        end
        SQ: begin
          s2    <= prod[15:0];
          state <= SCALE;
        end
        SCALE: begin
          out_data_q  <= sat;
          out_zero_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          // Zero operands arrive here without out_valid; raise it one cycle after accept.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;

endmodule

// File: doc/ln.md
LN -- requirements
Module: ln

Interface
REQ-001 SHALL have parameter LN2_Q16, default 45426, ln(2) in Q0.16.
REQ-002 SHALL have parameter C2_COEF, default 79, quadratic coefficient in 1/256 units (≈0.3086).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_data  input  9  operand A, unsigned UQ3.6 (value A/64).
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_data  output  8  ln(A/64), signed Q1.6.
REQ-011 SHALL have port out_zero  output  1  operand was zero; out_data forced to -128.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, SQ, SCALE, OUT; in_ready = (state==IDLE).
REQ-013 SHALL, in IDLE on in_valid&in_ready, latch M=in_data (9b) and K=+2 (4b signed); go to NORM, or to OUT with out_data=-128 and out_zero=1 when in_data==0.
REQ-014 SHALL, in NORM, go to SQ if M[8]==1, else set M=M<<1 and K=K-1 and stay in NORM (one bit per cycle).
REQ-015 SHALL, in SQ, compute S2=F*F (16b unsigned), F=M[7:0]; go to SCALE.
REQ-016 SHALL, in SCALE, compute LM=(F<<8)-((S2*C2_COEF)>>8) (17b, Q0.16 of ln(1+F/256)); R=K*LN2_Q16+LM (20b signed); Y=(R+512)>>>10 (arithmetic); out_data=saturate(Y,-128..127); out_zero=0; set out_valid; go to OUT.
REQ-017 SHALL use at most one multiplier, 16x8 unsigned, time-shared between SQ and SCALE.
REQ-018 SHALL hold out_data, out_zero, out_valid stable in OUT until out_ready; on out_valid&out_ready clear out_valid and return to IDLE (in_ready high next cycle).
REQ-019 SHALL keep one operation in flight; in_valid ignored outside IDLE.
REQ-020 SHALL give latency (accept edge to out_valid high) 3+(8-p) cycles, p = index of leading one of A; 1 cycle for A=0.
REQ-021 SHALL leave out_data/out_zero unchanged except on writes in REQ-013/REQ-016.

Reset
REQ-022 SHALL on rst=1 at a clock edge force state=IDLE, out_valid=0, out_data=0, out_zero=0, M=0, K=0.
REQ-023 SHALL abort any in-flight operation on reset with no result produced; in_ready=1 the cycle after rst deasserts.
REQ-024 SHALL give rst priority over every handshake occurring in the same cycle.

Configuration
REQ-025 SHALL honour macro LN_FAST_NORM_EN: when defined, NORM normalizes in one cycle via priority encoder (M=A<<(8-p), K=p-6), always proceeds to SQ, latency fixed at 3 cycles (1 for A=0).
REQ-026 SHALL, when LN_FAST_NORM_EN is undefined, use iterative NORM per REQ-014; out_data/out_zero bit-identical in both builds.

Verification
REQ-027 SHALL test A=64 (1.0) -> out_data=0, out_zero=0, latency 5 (iterative) / 3 (fast).
REQ-028 SHALL test A=128 -> out_data=44 (0.6875); A=32 -> out_data=-44; A=96 -> out_data=27.
REQ-029 SHALL test A=0 -> out_data=-128, out_zero=1, latency 1; A=1 -> -128 (saturated), out_zero=0, latency 11 iterative; A=511 -> 127 (saturated).
REQ-030 SHALL test backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, second in_valid not accepted; out_ready=1 -> in_ready=1 next cycle.
REQ-031 SHALL test reset mid-NORM with A=1 -> out_valid never rises for that operand; next operand A=128 -> 44.
REQ-032 SHALL sweep all 512 operands with random out_ready stalls against a bit-exact model of REQ-013..REQ-016 in both macro builds.
